// File: rtl/mmv_block_reader.sv
// Block reader master for the MemoryMapped interface: issues sequential reads under a credit
// limit and streams the responses out of a first-word-fall-through FIFO with an end-of-block flag.
module mmv_block_reader #(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned AWIDTH    = 32,
    parameter int unsigned LWIDTH    = 16,
    parameter int unsigned FIFODEPTH = 8
) (
    input  logic              reset,
    input  logic              clk,
    input  logic              start,
    input  logic [AWIDTH-1:0] addr,
    input  logic [LWIDTH-1:0] len,
    output logic              ready,
    output logic [AWIDTH-1:0] m_addr,
    output logic              m_wreq,
    output logic [DWIDTH-1:0] m_wdat,
    output logic              m_rreq,
    input  logic [DWIDTH-1:0] m_rdat,
    input  logic              m_rval,
    input  logic              m_busy,
    output logic [DWIDTH-1:0] o_dat,
    output logic              o_val,
    input  logic              o_rdy,
    output logic              o_eop
);

    localparam int unsigned PW = $clog2(FIFODEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              rreq_q, rreq_d;
    logic [LWIDTH-1:0] req_cnt_q, req_cnt_d;
    logic [LWIDTH-1:0] pop_cnt_q, pop_cnt_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     occ_q, occ_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DWIDTH-1:0] mem_q [FIFODEPTH];

    logic accept, push, pop, start_ok, last_pop, has_data, credit_ok;

    assign has_data = (occ_q != '0);
    assign accept   = rreq_q & ~m_busy;
    // Responses with nothing outstanding are stray and dropped.
    assign push     = m_rval & (outst_q != '0);
    assign pop      = has_data & o_rdy;
    assign start_ok = (state_q == StIdle) & start & (len != '0);
    assign last_pop = pop & (pop_cnt_q == LWIDTH'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StRun;
            StRun:   if (last_pop) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        req_cnt_d = req_cnt_q;
        pop_cnt_d = pop_cnt_q;
        outst_d   = outst_q + CW'(accept) - CW'(push);
        occ_d     = occ_q + CW'(push) - CW'(pop);
        if (start_ok) begin
            addr_d    = addr;
            req_cnt_d = len;
            pop_cnt_d = len;
        end else begin
            if (accept) begin
                addr_d    = addr_q + AWIDTH'(1);
                req_cnt_d = req_cnt_q - LWIDTH'(1);
            end
            if (pop) pop_cnt_d = pop_cnt_q - LWIDTH'(1);
        end
        // Issue only if one more read still fits beside everything in flight or buffered.
        credit_ok = ({1'b0, outst_d} + {1'b0, occ_d}) < SW'(FIFODEPTH);
        if (start_ok) begin
            rreq_d = 1'b1;
        end else if (rreq_q && !accept) begin
            rreq_d = 1'b1;
        end else begin
            rreq_d = (state_q == StRun) && (req_cnt_d != '0) && credit_ok;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            rreq_q    <= 1'b0;
            req_cnt_q <= '0;
            pop_cnt_q <= '0;
            outst_q   <= '0;
            occ_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < FIFODEPTH; i++) mem_q[i] <= '0;
        end else begin
            addr_q    <= addr_d;
            rreq_q    <= rreq_d;
            req_cnt_q <= req_cnt_d;
            pop_cnt_q <= pop_cnt_d;
            outst_q   <= outst_d;
            occ_q     <= occ_d;
            if (push) begin
                mem_q[wr_ptr_q] <= m_rdat;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_comb begin
        ready  = (state_q == StIdle);
        m_rreq = rreq_q;
        m_addr = addr_q;
        m_wreq = 1'b0;
        m_wdat = '0;
        o_val  = has_data;
        o_dat  = has_data ? mem_q[rd_ptr_q] : '0;
        o_eop  = has_data && (pop_cnt_q == LWIDTH'(1));
    end

endmodule

// File: tb/tb_mmv_block_reader.sv
// Directed bench for mmv_block_reader with a fixed-latency memory slave (data = addr[7:0]+0x90).
module tb_mmv_block_reader;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [LW-1:0] len = '0;
    logic          ready;
    logic [AW-1:0] m_addr;
    logic          m_wreq;
    logic [DW-1:0] m_wdat;
    logic          m_rreq;
    logic [DW-1:0] m_rdat;
    logic          m_rval;
    logic          m_busy = 1'b0;
    logic [DW-1:0] o_dat;
    logic          o_val;
    logic          o_rdy = 1'b0;
    logic          o_eop;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmv_block_reader #(
        .DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW), .FIFODEPTH(FD)
    ) dut (
        .reset(reset), .clk(clk), .start(start), .addr(addr), .len(len), .ready(ready),
        .m_addr(m_addr), .m_wreq(m_wreq), .m_wdat(m_wdat), .m_rreq(m_rreq), .m_rdat(m_rdat),
        .m_rval(m_rval), .m_busy(m_busy), .o_dat(o_dat), .o_val(o_val), .o_rdy(o_rdy),
        .o_eop(o_eop)
    );

    function automatic logic [DW-1:0] dat_of(input logic [AW-1:0] a);
        return a[7:0] + 8'h90;
    endfunction

    // Slave: answers every accepted read after lat cycles.
    int            lat = 1;
    logic [7:0]    vpipe = '0;
    logic [DW-1:0] dpipe [8] = '{default: '0};
    always @(posedge clk) begin
        vpipe    <= {vpipe[6:0], m_rreq & ~m_busy};
        dpipe[0] <= dat_of(m_addr);
        for (int i = 1; i < 8; i++) dpipe[i] <= dpipe[i-1];
    end
    assign m_rval = vpipe[lat-1];
    assign m_rdat = dpipe[lat-1];

    // Monitor of accepted requests, popped words and request-hold violations.
    int            cyc = 0, acc_cnt = 0, hold_err = 0;
    int            start_cyc = 0, last_pop_cyc = 0, ready_rise_cyc = 0;
    logic [AW-1:0] acc_addr[$];
    int            acc_cyc[$];
    logic [DW:0]   got[$];
    logic          prev_rreq = 1'b0, prev_busy = 1'b0, prev_ready = 1'b1;
    logic [AW-1:0] prev_addr = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            if (m_rreq && !m_busy) begin
                acc_cnt <= acc_cnt + 1;
                acc_addr.push_back(m_addr);
                acc_cyc.push_back(cyc);
            end
            if (prev_rreq && prev_busy && (!m_rreq || m_addr != prev_addr))
                hold_err <= hold_err + 1;
            if (o_val && o_rdy) begin
                got.push_back({o_eop, o_dat});
                last_pop_cyc <= cyc;
            end
            if (start && ready) start_cyc <= cyc;
            if (ready && !prev_ready) ready_rise_cyc <= cyc;
        end
        prev_rreq  <= m_rreq & reset;
        prev_busy  <= m_busy;
        prev_addr  <= m_addr;
        prev_ready <= ready;
    end

    task automatic do_start(input logic [AW-1:0] a, input logic [LW-1:0] l);
        @(negedge clk);
        start = 1'b1;
        addr  = a;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max, input bit rnd);
        int n = 0;
        do begin
            @(negedge clk);
            if (rnd) begin
                m_busy = 1'($urandom_range(0, 1));
                o_rdy  = ($urandom_range(0, 3) != 0);
            end
            n++;
        end while (!ready && n < max);
        checks++;
        if (!ready) begin
            failures++;
            $display("FAIL wait_idle: ready=%0b after %0d cycles, required 1", ready, n);
        end
        m_busy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", ready); end
        checks++; if (m_rreq !== 1'b0) begin failures++; $display("FAIL rst_rreq got=%0b exp=0", m_rreq); end
        checks++; if (m_addr !== '0) begin failures++; $display("FAIL rst_addr got=%h exp=0", m_addr); end
        checks++; if (m_wreq !== 1'b0) begin failures++; $display("FAIL rst_wreq got=%0b exp=0", m_wreq); end
        checks++; if (m_wdat !== '0) begin failures++; $display("FAIL rst_wdat got=%h exp=0", m_wdat); end
        checks++; if (o_val !== 1'b0) begin failures++; $display("FAIL rst_oval got=%0b exp=0", o_val); end
        checks++; if (o_eop !== 1'b0) begin failures++; $display("FAIL rst_oeop got=%0b exp=0", o_eop); end
        checks++; if (o_dat !== '0) begin failures++; $display("FAIL rst_odat got=%h exp=0", o_dat); end
    endtask

    task automatic test_basic();
        int gb = got.size();
        int ab = acc_addr.size();
        logic [DW:0] e;
        lat = 1; m_busy = 1'b0; o_rdy = 1'b1;
        do_start(32'h10, 16'd4);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL basic_ready_t1 got=%0b exp=0", ready); end
        checks++; if (m_rreq !== 1'b1) begin failures++; $display("FAIL basic_rreq_t1 got=%0b exp=1", m_rreq); end
        checks++; if (m_addr !== 32'h10) begin failures++; $display("FAIL basic_addr_t1 got=%h exp=10", m_addr); end
        wait_idle(50, 1'b0);
        @(negedge clk);
        checks++;
        if (acc_addr.size() - ab !== 4) begin
            failures++; $display("FAIL basic_acc_cnt got=%0d exp=4", acc_addr.size() - ab);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_addr[ab+i] !== 32'h10 + i) begin
                    failures++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, acc_addr[ab+i], 32'h10 + i);
                end
            end
            checks++;
            if (acc_cyc[ab+3] - acc_cyc[ab] !== 3 || acc_cyc[ab] !== start_cyc + 1) begin
                failures++; $display("FAIL basic_consecutive got=%0d,%0d exp=%0d,%0d",
                                     acc_cyc[ab], acc_cyc[ab+3], start_cyc + 1, start_cyc + 4);
            end
        end
        checks++;
        if (got.size() - gb !== 4) begin
            failures++; $display("FAIL basic_words got=%0d exp=4", got.size() - gb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = {(i == 3), 8'hA0 + 8'(i)};
                checks++;
                if (got[gb+i] !== e) begin
                    failures++; $display("FAIL basic_word[%0d] got=%h exp=%h", i, got[gb+i], e);
                end
            end
        end
        checks++;
        if (ready_rise_cyc !== last_pop_cyc + 1) begin
            failures++; $display("FAIL basic_ready_after got=%0d exp=%0d", ready_rise_cyc, last_pop_cyc + 1);
        end
        checks++;
        if (last_pop_cyc - start_cyc > 4 + 1 + 2) begin
            failures++; $display("FAIL basic_full_rate got=%0d exp<=7", last_pop_cyc - start_cyc);
        end
    endtask

    task automatic test_backpressure();
        int gb = got.size();
        int ab = acc_cnt;
        logic [DW:0] e;
        lat = 1; m_busy = 1'b0; o_rdy = 1'b0;
        do_start(32'h40, 16'd32);
        repeat (50) @(negedge clk);
        checks++; if (acc_cnt - ab !== 8) begin failures++; $display("FAIL bp_accepted got=%0d exp=8", acc_cnt - ab); end
        checks++; if (m_rreq !== 1'b0) begin failures++; $display("FAIL bp_rreq got=%0b exp=0", m_rreq); end
        checks++; if (o_val !== 1'b1) begin failures++; $display("FAIL bp_oval got=%0b exp=1", o_val); end
        checks++; if (got.size() - gb !== 0) begin failures++; $display("FAIL bp_popped got=%0d exp=0", got.size() - gb); end
        o_rdy = 1'b1;
        wait_idle(200, 1'b0);
        checks++;
        if (got.size() - gb !== 32) begin
            failures++; $display("FAIL bp_words got=%0d exp=32", got.size() - gb);
        end else begin
            for (int i = 0; i < 32; i++) begin
                e = {(i == 31), dat_of(32'h40 + i)};
                checks++;
                if (got[gb+i] !== e) begin
                    failures++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, got[gb+i], e);
                end
            end
        end
    endtask

    task automatic test_random();
        int gb = got.size();
        int ab = acc_cnt;
        int hb = hold_err;
        logic [DW:0] e;
        lat = 3; m_busy = 1'b0; o_rdy = 1'b1;
        do_start(32'h1F0, 16'd100);
        wait_idle(3000, 1'b1);
        o_rdy = 1'b1;
        @(negedge clk);
        checks++; if (acc_cnt - ab !== 100) begin failures++; $display("FAIL rnd_accepted got=%0d exp=100", acc_cnt - ab); end
        checks++; if (hold_err - hb !== 0) begin failures++; $display("FAIL rnd_hold_err got=%0d exp=0", hold_err - hb); end
        checks++;
        if (got.size() - gb !== 100) begin
            failures++; $display("FAIL rnd_words got=%0d exp=100", got.size() - gb);
        end else begin
            for (int i = 0; i < 100; i++) begin
                e = {(i == 99), dat_of(32'h1F0 + i)};
                checks++;
                if (got[gb+i] !== e) begin
                    failures++; $display("FAIL rnd_word[%0d] got=%h exp=%h", i, got[gb+i], e);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int ab = acc_addr.size();
        logic [AW-1:0] exp_a [4];
        exp_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        lat = 1; m_busy = 1'b0; o_rdy = 1'b1;
        do_start(32'hFFFF_FFFE, 16'd4);
        wait_idle(50, 1'b0);
        checks++;
        if (acc_addr.size() - ab !== 4) begin
            failures++; $display("FAIL wrap_cnt got=%0d exp=4", acc_addr.size() - ab);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_addr[ab+i] !== exp_a[i]) begin
                    failures++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, acc_addr[ab+i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_len0_ignore();
        int gb;
        int ab = acc_cnt;
        logic [DW:0] e;
        lat = 1; m_busy = 1'b0; o_rdy = 1'b1;
        do_start(32'h60, 16'd0);
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL len0_ready got=%0b exp=1", ready); end
        checks++; if (acc_cnt - ab !== 0) begin failures++; $display("FAIL len0_reqs got=%0d exp=0", acc_cnt - ab); end
        gb = got.size();
        ab = acc_cnt;
        o_rdy = 1'b0;
        do_start(32'h50, 16'd3);
        do_start(32'h80, 16'd9);
        o_rdy = 1'b1;
        wait_idle(100, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (acc_cnt - ab !== 3) begin failures++; $display("FAIL ign_reqs got=%0d exp=3", acc_cnt - ab); end
        checks++;
        if (got.size() - gb !== 3) begin
            failures++; $display("FAIL ign_words got=%0d exp=3", got.size() - gb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                e = {(i == 2), dat_of(32'h50 + i)};
                checks++;
                if (got[gb+i] !== e) begin
                    failures++; $display("FAIL ign_word[%0d] got=%h exp=%h", i, got[gb+i], e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int ab = acc_cnt;
        int n = 0;
        int val_seen = 0;
        int gb;
        logic [DW:0] e;
        lat = 3; m_busy = 1'b0; o_rdy = 1'b0;
        do_start(32'h30, 16'd8);
        while (acc_cnt - ab < 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (acc_cnt - ab !== 3) begin failures++; $display("FAIL mid_outstanding got=%0d exp=3", acc_cnt - ab); end
        reset = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%0b exp=1", ready); end
        checks++; if (m_rreq !== 1'b0) begin failures++; $display("FAIL mid_rreq got=%0b exp=0", m_rreq); end
        checks++; if (m_addr !== '0) begin failures++; $display("FAIL mid_addr got=%h exp=0", m_addr); end
        checks++; if (o_val !== 1'b0) begin failures++; $display("FAIL mid_oval got=%0b exp=0", o_val); end
        @(negedge clk);
        reset = 1'b1;
        o_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_val) val_seen++;
        end
        checks++; if (val_seen !== 0) begin failures++; $display("FAIL mid_late_rval got=%0d exp=0", val_seen); end
        checks++; if (m_rreq !== 1'b0) begin failures++; $display("FAIL mid_idle_rreq got=%0b exp=0", m_rreq); end
        gb = got.size();
        do_start(32'h20, 16'd2);
        wait_idle(50, 1'b0);
        checks++;
        if (got.size() - gb !== 2) begin
            failures++; $display("FAIL post_words got=%0d exp=2", got.size() - gb);
        end else begin
            for (int i = 0; i < 2; i++) begin
                e = {(i == 1), 8'hB0 + 8'(i)};
                checks++;
                if (got[gb+i] !== e) begin
                    failures++; $display("FAIL post_word[%0d] got=%h exp=%h", i, got[gb+i], e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_wrap();
        test_len0_ignore();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
